// File: rtl/uncached_router_pkg.sv
// common: shared bus types for the CPU data bus and the cache bus, plus router state and AXI constants.
// Holds the dbus/cbus request and response structs, msize_t, urouter_state_t and AXI_BURST_FIXED.
package common;
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2, MSIZE4, MSIZE8} msize_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0] strobe_t;
    typedef logic [7:0] axi_len_t;
    typedef logic [1:0] axi_burst_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        msize_t     size;
        addr_t      addr;
        strobe_t    strobe;
        word_t      data;
        axi_len_t   len;
        axi_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} urouter_state_t;
endpackage

// File: rtl/uncached_router_fsm.sv
// uncached_fsm: latches an accepted uncached request and runs it as a single-beat cache-bus transaction.
// Ports: clk, reset (sync, active-high); start plus addr/size/strobe/wdata (request to latch);
// ucresp in; idle, resp_valid, resp_data (response towards the CPU), ucreq out.
// With UNCACHED_POSTED_WRITE_EN defined, writes answer immediately and drain in DRAIN.
module uncached_fsm
    import common::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  addr_t             addr,
    input  msize_t            size,
    input  strobe_t           strobe,
    input  word_t             wdata,
    input  cbus_resp_t        ucresp,
    output logic              idle,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output cbus_req_t         ucreq
);
    urouter_state_t state, state_n;
    addr_t l_addr;
    msize_t l_size;
    strobe_t l_strobe;
    word_t l_data;
    logic [DATA_W-1:0] rdata;
    logic done, is_write;

    assign done = ucresp.ready && ucresp.last;
    assign is_write = |l_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            l_addr   <= '0;
            l_size   <= MSIZE1;
            l_strobe <= '0;
            l_data   <= '0;
            rdata    <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                l_addr   <= addr;
                l_size   <= size;
                l_strobe <= strobe;
                l_data   <= wdata;
                rdata    <= '0;
            end else if (state == REQ && done && !is_write) begin
                rdata <= ucresp.data[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
`ifdef UNCACHED_POSTED_WRITE_EN
            IDLE:    state_n = start ? (|strobe ? RESP : REQ) : IDLE;
            RESP:    state_n = is_write ? DRAIN : IDLE;
            DRAIN:   state_n = done ? IDLE : DRAIN;
`else
            IDLE:    state_n = start ? REQ : IDLE;
            RESP:    state_n = IDLE;
`endif
            REQ:     state_n = done ? RESP : REQ;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        idle           = state == IDLE;
        resp_valid     = state == RESP;
        resp_data      = rdata;
        ucreq          = '0;
        ucreq.valid    = state == REQ || state == DRAIN;
        ucreq.is_write = is_write;
        ucreq.size     = l_size;
        ucreq.addr     = l_addr;
        ucreq.strobe   = l_strobe;
        ucreq.data     = l_data;
        ucreq.len      = '0;
        ucreq.burst    = AXI_BURST_FIXED;
    end
endmodule

// File: rtl/uncached_router.sv
// uncached_router: routes physically addressed CPU data requests to the data cache or to a single-beat uncached bus.
// Ports: clk, reset (sync, active-high); dreq + uncached from translation, dresp back to the CPU;
// cache_dreq/cache_dresp to the data cache; ucreq/ucresp to the interconnect.
// Optional: UNCACHED_POSTED_WRITE_EN makes uncached writes posted (early data_ok).
module uncached_router
    import common::*;
#(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    input  logic       uncached,
    output dbus_resp_t dresp,
    output dbus_req_t  cache_dreq,
    input  dbus_resp_t cache_dresp,
    output cbus_req_t  ucreq,
    input  cbus_resp_t ucresp
);
    logic c_pending, idle, resp_valid, start, live;
    logic [DATA_W-1:0] resp_data;

    // A cached access is in flight between its addr_ok and data_ok.
    always_ff @(posedge clk) begin
        if (reset) c_pending <= 1'b0;
        else       c_pending <= (c_pending || cache_dresp.addr_ok) && !cache_dresp.data_ok;
    end

    // Idle and out of reset: the only window where either path may accept.
    assign live  = idle && !reset;
    assign start = live && dreq.valid && uncached && !c_pending;

    uncached_fsm #(.DATA_W(DATA_W)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (dreq.addr),
        .size       (dreq.size),
        .strobe     (dreq.strobe),
        .wdata      (dreq.data),
        .ucresp     (ucresp),
        .idle       (idle),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .ucreq      (ucreq)
    );

    always_comb begin
        cache_dreq    = live && !uncached ? dreq : '0;
        dresp         = resp_valid && !reset ? '{addr_ok: 1'b0, data_ok: 1'b1, data: resp_data}
                      : live ? cache_dresp : '0;
        dresp.addr_ok = dresp.addr_ok || start;
    end
endmodule

// File: tb/tb_uncached_router.sv
// tb_uncached_router: directed scoreboard bench for uncached_router; expected addr_ok/data_ok events are queued by the stimulus and matched by a monitor.
module tb_uncached_router;
    import common::*;

    logic clk = 1'b0;
    logic reset;
    logic uncached;
    dbus_req_t dreq, cache_dreq;
    dbus_resp_t dresp, cache_dresp;
    cbus_req_t ucreq;
    cbus_resp_t ucresp;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int c0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } exp_t;
    exp_t dq[$];
    int aq[$];

`ifdef UNCACHED_POSTED_WRITE_EN
    localparam int WOK = 1;
    localparam int RA = 4;
`else
    localparam int WOK = 4;
    localparam int RA = 5;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uncached_router #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .dreq        (dreq),
        .uncached    (uncached),
        .dresp       (dresp),
        .cache_dreq  (cache_dreq),
        .cache_dresp (cache_dresp),
        .ucreq       (ucreq),
        .ucresp      (ucresp)
    );

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, got, exp, cyc);
        end
    endtask

    task automatic bad(input string n);
        checks++;
        failures++;
        $display("FAIL %s got=event exp=none cyc=%0d", n, cyc);
    endtask

    function automatic dbus_req_t mk(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = MSIZE4;
        r.strobe = s;
        r.data   = d;
        return r;
    endfunction

    function automatic dbus_resp_t cr(input logic a, input logic d, input logic [31:0] w);
        dbus_resp_t r;
        r.addr_ok = a;
        r.data_ok = d;
        r.data    = w;
        return r;
    endfunction

    function automatic cbus_resp_t ur(input logic [31:0] w);
        cbus_resp_t r;
        r.ready = 1'b1;
        r.last  = 1'b1;
        r.data  = w;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dresp.data_ok) begin
                if (dq.size() == 0) bad("unexpected_data_ok");
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("data_ok_cycle", 128'(cyc), 128'(e.c));
                    chk("data_ok_data", 128'(dresp.data), 128'(e.d));
                end
            end
            if (dresp.addr_ok) begin
                if (aq.size() == 0) bad("unexpected_addr_ok");
                else chk("addr_ok_cycle", 128'(cyc), 128'(aq.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1;
        uncached = 1'b0;
        dreq = '0;
        cache_dresp = '0;
        ucresp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dresp", 128'(dresp), 128'(0));
        chk("rst_ucreq", 128'(ucreq), 128'(0));
        chk("rst_cache_dreq", 128'(cache_dreq), 128'(0));
        tick;
        reset = 1'b0;
        tick;

        c0 = cyc;
        dreq = mk(32'h1faf_f000, 4'h0, 32'h0);
        uncached = 1'b1;
        aq.push_back(c0);
        dq.push_back('{c0 + 4, 32'hdead_beef});
        tick;
        dreq.valid = 1'b0;
        @(negedge clk);
        chk("rd_ucreq_valid", 128'(ucreq.valid), 128'(1));
        chk("rd_ucreq_len", 128'(ucreq.len), 128'(0));
        chk("rd_ucreq_addr", 128'(ucreq.addr), 128'(32'h1faf_f000));
        chk("rd_ucreq_is_write", 128'(ucreq.is_write), 128'(0));
        chk("rd_ucreq_burst", 128'(ucreq.burst), 128'(0));
        tick;
        tick;
        ucresp = ur(32'hdead_beef);
        tick;
        ucresp = '0;
        @(negedge clk);
        chk("rd_ucreq_done", 128'(ucreq.valid), 128'(0));
        tick;
        tick;

        c0 = cyc;
        uncached = 1'b0;
        dreq = mk(32'h0000_1000, 4'hf, 32'ha5a5_0001);
        cache_dresp = cr(1'b1, 1'b0, 32'h0);
        aq.push_back(c0);
        @(negedge clk);
        chk("c_fwd", 128'(cache_dreq), 128'(dreq));
        chk("c_uc_quiet", 128'(ucreq.valid), 128'(0));
        tick;
        dreq.valid = 1'b0;
        cache_dresp = '0;
        tick;
        cache_dresp = cr(1'b0, 1'b1, 32'h1234_5678);
        dq.push_back('{c0 + 2, 32'h1234_5678});
        @(negedge clk);
        chk("c_resp", 128'(dresp), 128'(cache_dresp));
        tick;
        cache_dresp = '0;
        tick;

        c0 = cyc;
        dreq = mk(32'h0000_2000, 4'h0, 32'h0);
        cache_dresp = cr(1'b1, 1'b0, 32'h0);
        aq.push_back(c0);
        tick;
        cache_dresp = '0;
        dreq = mk(32'h1fd0_0010, 4'h0, 32'h0);
        uncached = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        chk("ord_blocked", 128'(ucreq.valid), 128'(0));
        tick;
        cache_dresp = cr(1'b0, 1'b1, 32'h0bad_cafe);
        dq.push_back('{c0 + 5, 32'h0bad_cafe});
        aq.push_back(c0 + 6);
        tick;
        cache_dresp = '0;
        tick;
        dreq.valid = 1'b0;
        ucresp = ur(32'h0000_55aa);
        dq.push_back('{c0 + 8, 32'h0000_55aa});
        tick;
        ucresp = '0;
        tick;
        tick;

        c0 = cyc;
        dreq = mk(32'h1fe0_0000, 4'hf, 32'h0000_0012);
        aq.push_back(c0);
        dq.push_back('{c0 + WOK, 32'h0});
        aq.push_back(c0 + RA);
        dq.push_back('{c0 + RA + 2, 32'h0000_0077});
        for (int i = 1; i <= RA + 3; i++) begin
            tick;
            if (i == 1) dreq = mk(32'h1fe0_0004, 4'h0, 32'h0);
            if (i == RA + 1) dreq.valid = 1'b0;
            ucresp = (i == 3) ? ur(32'h0) : (i == RA + 1) ? ur(32'h0000_0077) : '0;
            if (i == 2) begin
                @(negedge clk);
                chk("wr_ucreq_valid", 128'(ucreq.valid), 128'(1));
                chk("wr_ucreq_is_write", 128'(ucreq.is_write), 128'(1));
                chk("wr_ucreq_strobe", 128'(ucreq.strobe), 128'(4'hf));
                chk("wr_ucreq_data", 128'(ucreq.data), 128'(32'h12));
                chk("wr_ucreq_addr", 128'(ucreq.addr), 128'(32'h1fe0_0000));
            end
        end
        tick;

        c0 = cyc;
        dreq = mk(32'h1fc0_0000, 4'h0, 32'h0);
        aq.push_back(c0);
        tick;
        dreq.valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ucreq", 128'(ucreq.valid), 128'(0));
        repeat (3) tick;
        @(negedge clk);
        chk("rst_mid_ucreq_late", 128'(ucreq.valid), 128'(0));
        tick;
        c0 = cyc;
        dreq = mk(32'h1fc0_0004, 4'h0, 32'h0);
        aq.push_back(c0);
        dq.push_back('{c0 + 2, 32'hcafe_0001});
        tick;
        dreq.valid = 1'b0;
        ucresp = ur(32'hcafe_0001);
        tick;
        ucresp = '0;
        repeat (3) tick;
        @(negedge clk);
        chk("data_q_empty", 128'(dq.size()), 128'(0));
        chk("addr_q_empty", 128'(aq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
